// File: rtl/pdua_int_ctrl.sv
// Prioritised, maskable, non-nesting interrupt controller for PDUA.
// Rising edges latch as pending; the lowest enabled line is granted a vector.
module pdua_int_ctrl #(
  parameter int               N_IRQ    = 4,
  parameter int               VEC_W    = 8,
  parameter logic [VEC_W-1:0] VEC_BASE = 'hF8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             ien_we,
  input  logic [N_IRQ-1:0] ien_din,
  input  logic             inta,
  input  logic             eoi,
  output logic             INT,
  output logic [VEC_W-1:0] vector,
  output logic             vec_valid,
  output logic             in_srv,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] ien
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SRV
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] evt;
  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] clr;
  logic [IW-1:0]    cur;
  logic [IW-1:0]    sel;
  logic             any_req;
  logic             ack;

  assign evt     = irq & ~irq_q;
  assign req     = pending & ien;
  assign any_req = |req;
  assign ack     = (state == REQ) && inta;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel = IW'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (ack) clr[cur] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_q     <= irq;
      pending   <= '0;
      ien       <= '0;
      cur       <= '0;
      vector    <= '0;
      INT       <= 1'b0;
      vec_valid <= 1'b0;
      in_srv    <= 1'b0;
    end else begin
      irq_q     <= irq;
      // A fresh edge on the acknowledged line outranks its clear.
      pending   <= (pending & ~clr) | evt;
      vec_valid <= 1'b0;
      if (ien_we) ien <= ien_din;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            cur    <= sel;
            vector <= VEC_BASE + VEC_W'(sel);
            INT    <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (inta) begin
            INT       <= 1'b0;
            vec_valid <= 1'b1;
            in_srv    <= 1'b1;
            state     <= SRV;
          end
        end
        SRV: begin
          if (eoi) begin
            in_srv <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
